// File: rtl/bus_ser.sv
// bus_ser: transmit-side serializer for the shared 73-bit BUS.
// Takes one packet from the local block, requests the bus from the BAU,
// then drives the packet as 1..4 beats of 32 data bits, highest slot first,
// finishing on slot 0 which the receiver treats as the completion beat.
// The SystemVerilog keyword 'return' cannot name a port, so the return node
// ID input is called return_id.

module bus_ser #(
    parameter logic [3:0] loc     = 4'd0,
    parameter int         MAXBEAT = 4
) (
    input  logic         clk_bus,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready,
    input  logic [14:0]  pAdr,
    input  logic [127:0] data,
    input  logic [3:0]   return_id,
    input  logic [3:0]   dest,
    input  logic         rw,
    input  logic [15:0]  size,
    output logic         req_bau,
    output logic [3:0]   dest_bau,
    output logic [3:0]   src_bau,
    input  logic         grant_bau,
    output logic         done,
    inout  wire  [72:0]  BUS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [14:0]    padr_q;
    logic [127:0]   data_q;
    logic [3:0]     ret_q;
    logic [3:0]     dest_q;
    logic           rw_q;
    logic [1:0]     last_slot_q;
    logic [1:0]     slot_q;
    logic           done_q;
    logic           done_d;

    logic           accept;
    logic           grant_take;
    logic [14:0]    quad;
    logic [2:0]     nbeat;
    logic [3:0]     slot_onehot;
    logic [72:0]    beat;

    // Beat count from the byte size; the +3 is done in 17 bits so 0xFFFF
    // cannot wrap to a small count, and a zero size still sends one beat.
    always_comb begin
        nbeat = 3'd1;
        quad  = 15'(({1'b0, size} + 17'd3) >> 2);
        if (size == 16'd0) begin
            nbeat = 3'd1;
        end else if (quad >= 15'(MAXBEAT)) begin
            nbeat = 3'(MAXBEAT);
        end else begin
            nbeat = quad[2:0];
        end
    end

    // Next-state and handshake outputs; the bus stays locked once granted,
    // so grant_bau is only looked at while requesting.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        req_bau    = 1'b0;
        done_d     = 1'b0;
        accept     = 1'b0;
        grant_take = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (valid_in) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                req_bau = 1'b1;
                if (grant_bau) begin
                    grant_take = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (slot_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the registered done pulse that follows slot 0.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Holding registers capture the whole packet on the accepting edge so the
    // block may change its inputs while the packet is still in flight.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            padr_q      <= '0;
            data_q      <= '0;
            ret_q       <= '0;
            dest_q      <= '0;
            rw_q        <= 1'b0;
            last_slot_q <= '0;
        end else if (accept) begin
            padr_q      <= pAdr;
            data_q      <= data;
            ret_q       <= return_id;
            dest_q      <= dest;
            rw_q        <= rw;
            last_slot_q <= 2'(nbeat - 3'd1);
        end
    end

    // Slot counter: loaded with the highest slot on grant, counts down to 0.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            slot_q <= '0;
        end else if (grant_take) begin
            slot_q <= last_slot_q;
        end else if (state_q == SEND && slot_q != 2'd0) begin
            slot_q <= slot_q - 2'd1;
        end
    end

    // Assemble the beat for the current slot; its size field carries a
    // one-hot slot marker instead of the byte count.
    always_comb begin
        slot_onehot = 4'b0001 << slot_q;
        beat        = {12'b0, slot_onehot, rw_q, dest_q, ret_q,
                       data_q[{slot_q, 5'd0} +: 32], padr_q, 1'b1};
    end

    // Drive enable comes from the state register alone, keeping grant_bau
    // off any combinational path onto the shared bus.
    assign BUS      = (state_q == SEND) ? beat : {73{1'bz}};
    assign done     = done_q;
    assign dest_bau = dest_q;
    assign src_bau  = loc;

endmodule

// File: tb/tb_bus_ser.sv
// tb_bus_ser: exercises bus_ser with fixed and random packets against a
// packet-level model of the beats the receiver should see.

module tb_bus_ser;

    typedef struct packed {
        logic [14:0]  padr;
        logic [127:0] data;
        logic [3:0]   ret;
        logic [3:0]   dest;
        logic         rw;
        logic [15:0]  size;
    } pkt_t;

    localparam logic [72:0] IDLE_BUS = {73{1'b1}};

    logic         clk_bus = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic         ready;
    logic [14:0]  pAdr = '0;
    logic [127:0] data = '0;
    logic [3:0]   return_id = '0;
    logic [3:0]   dest = '0;
    logic         rw = 1'b0;
    logic [15:0]  size = '0;
    logic         req_bau;
    logic [3:0]   dest_bau;
    logic [3:0]   src_bau;
    logic         grant_bau = 1'b0;
    logic         done;
    wire  [72:0]  bus_w;

    int tests = 0;
    int fails = 0;

    logic [72:0] seen[$];
    logic        done_seen;
    int          req_cycles;
    int          idle_in_req;

    // An undriven bus floats up to all ones, so a released bus is visible.
    pullup (bus_w);

    bus_ser dut (
        .clk_bus   (clk_bus),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready     (ready),
        .pAdr      (pAdr),
        .data      (data),
        .return_id (return_id),
        .dest      (dest),
        .rw        (rw),
        .size      (size),
        .req_bau   (req_bau),
        .dest_bau  (dest_bau),
        .src_bau   (src_bau),
        .grant_bau (grant_bau),
        .done      (done),
        .BUS       (bus_w)
    );

    // Free-running bus clock.
    always #5 clk_bus = ~clk_bus;

    function automatic int model_nbeat(input logic [15:0] sz);
        int n;
        if (sz == 16'd0) return 1;
        n = (int'(sz) + 3) / 4;
        return (n > 4) ? 4 : n;
    endfunction

    function automatic logic [72:0] model_beat(input pkt_t p, input int s);
        logic [72:0] w;
        w        = '0;
        w[0]     = 1'b1;
        w[15:1]  = p.padr;
        w[47:16] = p.data[32*s +: 32];
        w[51:48] = p.ret;
        w[55:52] = p.dest;
        w[56]    = p.rw;
        w[72:57] = 16'd1 << s;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic rand_pkt(output pkt_t p, input logic [15:0] sz);
        p.padr = 15'($urandom);
        p.data = {$urandom, $urandom, $urandom, $urandom};
        p.ret  = 4'($urandom);
        p.dest = 4'($urandom);
        p.rw   = 1'($urandom);
        p.size = sz;
    endtask

    task automatic drive_inputs(input pkt_t p);
        pAdr      = p.padr;
        data      = p.data;
        return_id = p.ret;
        dest      = p.dest;
        rw        = p.rw;
        size      = p.size;
    endtask

    // Offer one packet, grant after gdelay request cycles, then record every
    // bus word until done shows up (bounded).
    task automatic run_packet(input pkt_t p, input int gdelay, input bit rand_grant);
        drive_inputs(p);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        req_cycles  = 0;
        idle_in_req = 0;
        for (int i = 0; i < gdelay; i++) begin
            if (req_bau === 1'b1 && dest_bau === p.dest && ready === 1'b0) req_cycles++;
            if (bus_w === IDLE_BUS) idle_in_req++;
            tick();
        end
        grant_bau = 1'b1;
        tick();
        grant_bau = 1'b0;
        seen.delete();
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            seen.push_back(bus_w);
            if (rand_grant) grant_bau = 1'($urandom);
            tick();
        end
        grant_bau = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        grant_bau = 1'b1;
        tick();
        tick();
        tests++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        tests++; if (req_bau !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b want 0", req_bau); end
        tests++; if (bus_w !== IDLE_BUS) begin fails++; $display("[TB] FAIL reset_bus got %h want %h", bus_w, IDLE_BUS); end
        tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
        tests++; if (dest_bau !== 4'd0) begin fails++; $display("[TB] FAIL reset_dest_bau got %h want 0", dest_bau); end
        tests++; if (src_bau !== 4'd0) begin fails++; $display("[TB] FAIL src_bau got %h want 0", src_bau); end
        rst = 1'b0;
        grant_bau = 1'b0;
        tick();
    endtask

    task automatic test_grant_idle();
        grant_bau = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (req_bau !== 1'b0 || ready !== 1'b1 || bus_w !== IDLE_BUS) begin
                fails++; $display("[TB] FAIL grant_idle req=%b ready=%b bus=%h want req=0 ready=1 bus idle", req_bau, ready, bus_w);
            end
        end
        grant_bau = 1'b0;
        tick();
    endtask

    task automatic test_four_beat();
        pkt_t p;
        logic [15:0] exp_sz[4];
        logic [31:0] exp_data[4];
        exp_sz   = '{16'd8, 16'd4, 16'd2, 16'd1};
        exp_data = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rand_pkt(p, 16'd16);
        p.data = 128'h44444444_33333333_22222222_11111111;
        run_packet(p, 1, 1'b0);
        tests++; if (req_cycles != 1) begin fails++; $display("[TB] FAIL four_req got %0d want 1", req_cycles); end
        tests++; if (seen.size() != 4) begin fails++; $display("[TB] FAIL four_nbeat got %0d want 4", seen.size()); end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            tests++; if (seen[k] !== model_beat(p, 3 - k)) begin fails++; $display("[TB] FAIL four_beat%0d got %h want %h", k, seen[k], model_beat(p, 3 - k)); end
            tests++; if (seen[k][72:57] !== exp_sz[k]) begin fails++; $display("[TB] FAIL four_size%0d got %h want %h", k, seen[k][72:57], exp_sz[k]); end
            tests++; if (seen[k][47:16] !== exp_data[k]) begin fails++; $display("[TB] FAIL four_data%0d got %h want %h", k, seen[k][47:16], exp_data[k]); end
        end
        tests++; if (!done_seen) begin fails++; $display("[TB] FAIL four_done got 0 want 1"); end
        tests++; if (bus_w !== IDLE_BUS || ready !== 1'b1) begin fails++; $display("[TB] FAIL four_after bus=%h ready=%b want idle,1", bus_w, ready); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL four_done_pulse got %b want 0", done); end
    endtask

    task automatic test_grant_delay();
        pkt_t p;
        rand_pkt(p, 16'd4);
        p.dest = 4'd5;
        run_packet(p, 7, 1'b0);
        tests++; if (req_cycles != 7) begin fails++; $display("[TB] FAIL delay_req got %0d want 7", req_cycles); end
        tests++; if (idle_in_req != 7) begin fails++; $display("[TB] FAIL delay_bus_idle got %0d want 7", idle_in_req); end
        tests++; if (seen.size() != 1) begin fails++; $display("[TB] FAIL delay_nbeat got %0d want 1", seen.size()); end
        if (seen.size() > 0) begin
            tests++; if (seen[0] !== model_beat(p, 0)) begin fails++; $display("[TB] FAIL delay_beat got %h want %h", seen[0], model_beat(p, 0)); end
            tests++; if (seen[0][72:57] !== 16'd1) begin fails++; $display("[TB] FAIL delay_size got %h want 1", seen[0][72:57]); end
        end
        tests++; if (!done_seen) begin fails++; $display("[TB] FAIL delay_done got 0 want 1"); end
        tests++; if (bus_w !== IDLE_BUS) begin fails++; $display("[TB] FAIL delay_after got %h want idle", bus_w); end
        tick();
    endtask

    task automatic test_beat_count();
        logic [15:0] sizes[10];
        pkt_t p;
        logic [15:0] sz;
        int n;
        sizes = '{16'd0, 16'd9, 16'hFFFF, 16'd1, 16'd4, 16'd5, 16'd12, 16'd13, 16'd16, 16'd17};
        for (int t = 0; t < 30; t++) begin
            if (t < 10) sz = sizes[t];
            else if (t % 2 == 0) sz = 16'($urandom_range(0, 24));
            else sz = 16'($urandom);
            rand_pkt(p, sz);
            n = model_nbeat(sz);
            run_packet(p, int'($urandom_range(0, 3)), 1'b1);
            tests++; if (seen.size() != n) begin fails++; $display("[TB] FAIL count_nbeat size=%h got %0d want %0d", sz, seen.size(), n); end
            for (int k = 0; k < seen.size() && k < n; k++) begin
                tests++; if (seen[k] !== model_beat(p, n - 1 - k)) begin
                    fails++; $display("[TB] FAIL count_beat size=%h k=%0d got %h want %h", sz, k, seen[k], model_beat(p, n - 1 - k));
                end
            end
            tests++; if (!done_seen) begin fails++; $display("[TB] FAIL count_done size=%h got 0 want 1", sz); end
            tick();
            tests++; if (done !== 1'b0 || bus_w !== IDLE_BUS) begin fails++; $display("[TB] FAIL count_after done=%b bus=%h want 0,idle", done, bus_w); end
        end
    endtask

    task automatic test_back_to_back();
        pkt_t a;
        pkt_t b;
        int busy_ok;
        rand_pkt(a, 16'd16);
        drive_inputs(a);
        valid_in = 1'b1;
        tick();
        busy_ok = 0;
        for (int i = 0; i < 2; i++) begin
            if (ready === 1'b0) busy_ok++;
            rand_pkt(b, 16'($urandom_range(0, 40)));
            drive_inputs(b);
            tick();
        end
        grant_bau = 1'b1;
        tick();
        grant_bau = 1'b0;
        seen.delete();
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (ready === 1'b0) busy_ok++;
            seen.push_back(bus_w);
            rand_pkt(b, 16'($urandom_range(0, 40)));
            drive_inputs(b);
            tick();
        end
        tests++; if (busy_ok != 6) begin fails++; $display("[TB] FAIL b2b_busy got %0d want 6", busy_ok); end
        tests++; if (seen.size() != 4) begin fails++; $display("[TB] FAIL b2b_first_nbeat got %0d want 4", seen.size()); end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            tests++; if (seen[k] !== model_beat(a, 3 - k)) begin fails++; $display("[TB] FAIL b2b_first_beat%0d got %h want %h", k, seen[k], model_beat(a, 3 - k)); end
        end
        tests++; if (!done_seen || ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_done done=%b ready=%b want 1,1", done_seen, ready); end
        tick();
        valid_in = 1'b0;
        tests++; if (req_bau !== 1'b1 || dest_bau !== b.dest || ready !== 1'b0) begin
            fails++; $display("[TB] FAIL b2b_second_req req=%b dest=%h ready=%b want 1,%h,0", req_bau, dest_bau, ready, b.dest);
        end
        grant_bau = 1'b1;
        tick();
        grant_bau = 1'b0;
        seen.delete();
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            seen.push_back(bus_w);
            tick();
        end
        tests++; if (seen.size() != model_nbeat(b.size)) begin fails++; $display("[TB] FAIL b2b_second_nbeat got %0d want %0d", seen.size(), model_nbeat(b.size)); end
        for (int k = 0; k < seen.size() && k < model_nbeat(b.size); k++) begin
            tests++; if (seen[k] !== model_beat(b, model_nbeat(b.size) - 1 - k)) begin
                fails++; $display("[TB] FAIL b2b_second_beat%0d got %h want %h", k, seen[k], model_beat(b, model_nbeat(b.size) - 1 - k));
            end
        end
        tests++; if (!done_seen) begin fails++; $display("[TB] FAIL b2b_second_done got 0 want 1"); end
        tick();
    endtask

    task automatic test_reset_mid_send();
        pkt_t p;
        int done_count;
        rand_pkt(p, 16'd16);
        drive_inputs(p);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        grant_bau = 1'b1;
        tick();
        grant_bau = 1'b0;
        tests++; if (bus_w !== model_beat(p, 3)) begin fails++; $display("[TB] FAIL midrst_beat3 got %h want %h", bus_w, model_beat(p, 3)); end
        tick();
        tests++; if (bus_w !== model_beat(p, 2)) begin fails++; $display("[TB] FAIL midrst_beat2 got %h want %h", bus_w, model_beat(p, 2)); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (bus_w !== IDLE_BUS) begin fails++; $display("[TB] FAIL midrst_bus got %h want idle", bus_w); end
        tests++; if (ready !== 1'b1 || req_bau !== 1'b0) begin fails++; $display("[TB] FAIL midrst_ctrl ready=%b req=%b want 1,0", ready, req_bau); end
        done_count = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1 || bus_w !== IDLE_BUS) done_count++;
        end
        tests++; if (done_count != 0) begin fails++; $display("[TB] FAIL midrst_done got %0d pulses want 0", done_count); end
    endtask

    // Hard time limit in case the design stalls somewhere.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached, tests=%0d", tests);
        $fatal(1, "[TB] time limit");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_grant_idle();
        test_four_beat();
        test_grant_delay();
        test_beat_count();
        test_back_to_back();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
